// File: rtl/sextium_io_port_pkg.sv
// Shared definitions for the Sextium buffered I/O port: FSM state encodings
// and the core data-bus width used as the default word size.
package sextium_io_port_pkg;

  localparam int CORE_WIDTH = 16;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_LOW = 1'b1
  } state_t;

endpackage

// File: rtl/sextium_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; pushes when full and pops
// when empty are ignored, so callers may present requests unconditionally.
module sextium_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sextium_io_port.sv
// Buffered core I/O device: services level-held io_read/io_write requests from
// host-fed input and host-drained output FIFOs, acknowledging each exactly once.
module sextium_io_port
  import sextium_io_port_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = CORE_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_read,
  input  logic                       io_write,
  input  logic [WIDTH-1:0]           io_data_in,
  output logic [WIDTH-1:0]           io_data_out,
  output logic                       ioack,
  input  logic [WIDTH-1:0]           host_in_data,
  input  logic                       host_in_valid,
  output logic                       host_in_ready,
  output logic [WIDTH-1:0]           host_out_data,
  output logic                       host_out_valid,
  input  logic                       host_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] in_count,
  output logic [$clog2(DEPTH+1)-1:0] out_count,
  output logic                       proto_err
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             r_ack;
  logic             r_err;

  logic             w_in_pop;
  logic             w_out_push;
  logic             w_ack_next;
  logic             w_load;
  logic             w_err_set;
  logic [WIDTH-1:0] w_in_dout;
  logic             w_in_full;
  logic             w_in_empty;
  logic             w_out_full;
  logic             w_out_empty;

  sextium_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .push  (host_in_valid && !w_in_full),
    .pop   (w_in_pop),
    .din   (host_in_data),
    .dout  (w_in_dout),
    .full  (w_in_full),
    .empty (w_in_empty),
    .count (in_count)
  );

  sextium_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_out_push),
    .pop   (host_out_ready && !w_out_empty),
    .din   (io_data_in),
    .dout  (host_out_data),
    .full  (w_out_full),
    .empty (w_out_empty),
    .count (out_count)
  );

  assign host_in_ready  = !w_in_full;
  assign host_out_valid = !w_out_empty;
  assign io_data_out    = r_data;
  assign ioack          = r_ack;
  assign proto_err      = r_err;

  always_comb begin
    w_state_next = r_state;
    w_in_pop     = 1'b0;
    w_out_push   = 1'b0;
    w_ack_next   = 1'b0;
    w_load       = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_read && io_write) begin
          w_err_set = 1'b1;
        end else if (io_read && !w_in_empty) begin
          w_in_pop     = 1'b1;
          w_load       = 1'b1;
          w_ack_next   = 1'b1;
          w_state_next = ST_WAIT_LOW;
        end else if (io_write && !w_out_full) begin
          w_out_push   = 1'b1;
          w_ack_next   = 1'b1;
          w_state_next = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        // Hold off until the core drops its request so it is serviced once.
        if (!io_read && !io_write) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack_next;
      if (w_load) begin
        r_data <= w_in_dout;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sextium_io_port.sv
// Directed self-checking bench for sextium_io_port: read/write handshakes,
// stalls on empty/full FIFOs, protocol error and reset behaviour.
module tb_sextium_io_port;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             io_read;
  logic             io_write;
  logic [WIDTH-1:0] io_data_in;
  logic [WIDTH-1:0] io_data_out;
  logic             ioack;
  logic [WIDTH-1:0] host_in_data;
  logic             host_in_valid;
  logic             host_in_ready;
  logic [WIDTH-1:0] host_out_data;
  logic             host_out_valid;
  logic             host_out_ready;
  logic [CW-1:0]    in_count;
  logic [CW-1:0]    out_count;
  logic             proto_err;

  int checks = 0;
  int errors = 0;

  sextium_io_port #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .io_read        (io_read),
    .io_write       (io_write),
    .io_data_in     (io_data_in),
    .io_data_out    (io_data_out),
    .ioack          (ioack),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .in_count       (in_count),
    .out_count      (out_count),
    .proto_err      (proto_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    io_read        = 1'b0;
    io_write       = 1'b0;
    io_data_in     = '0;
    host_in_data   = '0;
    host_in_valid  = 1'b0;
    host_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ack", 32'(ioack), 32'd0);
    chk("rst_dout", 32'(io_data_out), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    chk("rst_in_cnt", 32'(in_count), 32'd0);
    chk("rst_out_cnt", 32'(out_count), 32'd0);
    chk("rst_out_valid", 32'(host_out_valid), 32'd0);
    chk("rst_in_ready", 32'(host_in_ready), 32'd1);
    $display("reset: checks=%0d errors=%0d", checks, errors);

    // Two host words, two held reads
    host_in_valid = 1'b1;
    host_in_data  = 16'h1234;
    tick();
    host_in_data  = 16'hBEEF;
    tick();
    host_in_valid = 1'b0;
    chk("rd_in_cnt2", 32'(in_count), 32'd2);
    io_read = 1'b1;
    tick();
    chk("rd1_ack", 32'(ioack), 32'd1);
    chk("rd1_data", 32'(io_data_out), 32'h1234);
    chk("rd1_in_cnt", 32'(in_count), 32'd1);
    tick();
    chk("rd1_ack_drop", 32'(ioack), 32'd0);
    tick();
    chk("rd1_held_ack", 32'(ioack), 32'd0);
    chk("rd1_held_cnt", 32'(in_count), 32'd1);
    io_read = 1'b0;
    tick();
    io_read = 1'b1;
    tick();
    chk("rd2_ack", 32'(ioack), 32'd1);
    chk("rd2_data", 32'(io_data_out), 32'hBEEF);
    chk("rd2_in_cnt", 32'(in_count), 32'd0);
    io_read = 1'b0;
    tick();
    chk("rd2_ack_drop", 32'(ioack), 32'd0);
    $display("read pair: data=%h checks=%0d errors=%0d", io_data_out, checks, errors);

    // Read stalls on an empty input FIFO
    io_read = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_rd_ack", 32'(ioack), 32'd0);
    end
    host_in_valid = 1'b1;
    host_in_data  = 16'h00A5;
    tick();
    host_in_valid = 1'b0;
    chk("stall_push_ack", 32'(ioack), 32'd0);
    chk("stall_push_cnt", 32'(in_count), 32'd1);
    tick();
    chk("stall_rd_done", 32'(ioack), 32'd1);
    chk("stall_rd_data", 32'(io_data_out), 32'h00A5);
    io_read = 1'b0;
    tick();
    $display("read stall: data=%h checks=%0d errors=%0d", io_data_out, checks, errors);

    // Fill output FIFO, then a write stalls until the host pops
    for (int i = 0; i < DEPTH; i++) begin
      io_write   = 1'b1;
      io_data_in = 16'(i);
      tick();
      chk("wr_fill_ack", 32'(ioack), 32'd1);
      io_write = 1'b0;
      tick();
    end
    chk("wr_full_cnt", 32'(out_count), 32'(DEPTH));
    chk("wr_full_valid", 32'(host_out_valid), 32'd1);
    chk("wr_full_head", 32'(host_out_data), 32'd0);
    io_write   = 1'b1;
    io_data_in = 16'hFFFF;
    tick();
    chk("wr_stall_ack1", 32'(ioack), 32'd0);
    tick();
    chk("wr_stall_ack2", 32'(ioack), 32'd0);
    chk("wr_stall_cnt", 32'(out_count), 32'(DEPTH));
    host_out_ready = 1'b1;
    tick();
    chk("wr_pop_same_ack", 32'(ioack), 32'd0);
    chk("wr_pop_cnt", 32'(out_count), 32'(DEPTH - 1));
    chk("wr_pop_head", 32'(host_out_data), 32'd1);
    host_out_ready = 1'b0;
    tick();
    chk("wr_late_ack", 32'(ioack), 32'd1);
    chk("wr_late_cnt", 32'(out_count), 32'(DEPTH));
    io_write = 1'b0;
    tick();
    host_out_ready = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      chk("drain_valid", 32'(host_out_valid), 32'd1);
      chk("drain_data", 32'(host_out_data), 32'(k));
      tick();
    end
    chk("drain_last", 32'(host_out_data), 32'hFFFF);
    tick();
    chk("drain_empty", 32'(host_out_valid), 32'd0);
    chk("drain_cnt", 32'(out_count), 32'd0);
    host_out_ready = 1'b0;
    $display("write/drain: checks=%0d errors=%0d", checks, errors);

    // Full input FIFO: host push refused in the cycle the core pops
    host_in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      host_in_data = 16'(16'h0100 + i);
      tick();
    end
    chk("infull_cnt", 32'(in_count), 32'(DEPTH));
    chk("infull_ready", 32'(host_in_ready), 32'd0);
    host_in_data = 16'h0777;
    io_read      = 1'b1;
    tick();
    chk("infull_rd_ack", 32'(ioack), 32'd1);
    chk("infull_rd_data", 32'(io_data_out), 32'h0100);
    chk("infull_refused_cnt", 32'(in_count), 32'(DEPTH - 1));
    chk("infull_ready_after", 32'(host_in_ready), 32'd1);
    tick();
    host_in_valid = 1'b0;
    chk("infull_accept_cnt", 32'(in_count), 32'(DEPTH));
    chk("infull_no_reread", 32'(ioack), 32'd0);
    io_read = 1'b0;
    tick();
    $display("input full: count=%0d checks=%0d errors=%0d", in_count, checks, errors);

    // Protocol error
    io_read  = 1'b1;
    io_write = 1'b1;
    tick();
    chk("perr_ack", 32'(ioack), 32'd0);
    chk("perr_set", 32'(proto_err), 32'd1);
    chk("perr_no_pop", 32'(in_count), 32'(DEPTH));
    io_read  = 1'b0;
    io_write = 1'b0;
    tick();
    tick();
    chk("perr_sticky", 32'(proto_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("perr_cleared", 32'(proto_err), 32'd0);
    chk("perr_rst_in_cnt", 32'(in_count), 32'd0);
    chk("perr_rst_out_cnt", 32'(out_count), 32'd0);
    $display("proto err: checks=%0d errors=%0d", checks, errors);

    // Reset on the edge an ack would be produced
    host_in_valid = 1'b1;
    host_in_data  = 16'h5555;
    tick();
    host_in_valid = 1'b0;
    io_read = 1'b1;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstack_ack", 32'(ioack), 32'd0);
    chk("rstack_cnt", 32'(in_count), 32'd0);
    chk("rstack_data", 32'(io_data_out), 32'd0);
    tick();
    chk("rstack_wait", 32'(ioack), 32'd0);
    host_in_valid = 1'b1;
    host_in_data  = 16'h6666;
    tick();
    host_in_valid = 1'b0;
    chk("rstack_push_ack", 32'(ioack), 32'd0);
    tick();
    chk("rstack_serviced", 32'(ioack), 32'd1);
    chk("rstack_svc_data", 32'(io_data_out), 32'h6666);
    io_read = 1'b0;
    tick();
    $display("reset mid-request: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
